// File: rtl/calc_stream_controller_if.sv
// Memory and ALU bus of the calculator stream controller.
// The master side is the controller; the slave side is memory plus the external ALU.
interface calc_stream_controller_if #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
);
  logic                     read;
  logic [ADDR_W-1:0]        r_addr;
  logic [MEM_WORD_SIZE-1:0] r_data;
  logic                     write;
  logic [ADDR_W-1:0]        w_addr;
  logic [MEM_WORD_SIZE-1:0] w_data;
  logic [DATA_W-1:0]        op_a;
  logic [DATA_W-1:0]        op_b;
  logic [DATA_W-1:0]        result_i;

  modport master (
    output read, r_addr, write, w_addr, w_data, op_a, op_b,
    input  r_data, result_i
  );

  modport slave (
    input  read, r_addr, write, w_addr, w_data, op_a, op_b,
    output r_data, result_i
  );
endinterface

// File: rtl/calc_stream_controller.sv
// Memory-to-memory sequencer: reads operand words, feeds the ALU one word at a time,
// and packs PACK results per written word into a write address window.
module calc_stream_controller #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int READ_LAT      = 1,
  parameter int PACK          = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr,
  calc_stream_controller_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              range_err_o
);
  localparam int RES_W  = MEM_WORD_SIZE / PACK;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t                     state, state_n;
  logic [ADDR_W-1:0]          rd_ptr, wr_ptr;
  logic [LANE_W-1:0]          lane;
  logic [CNT_W-1:0]           cnt;
  logic [PACK-1:0][RES_W-1:0] buffer;
  logic [RES_W-1:0]           res_lane;
  logic                       last_rd, last_lane, last_wait, last_wr, rev, abort_now;

  assign last_rd   = rd_ptr == read_end_addr;
  assign last_wr   = wr_ptr == write_end_addr;
  assign last_lane = lane == LANE_W'(PACK - 1);
  assign last_wait = cnt == CNT_W'(READ_LAT - 1);
  assign rev       = (read_start_addr > read_end_addr) || (write_start_addr > write_end_addr);
  assign busy_o    = !(state == S_IDLE || state == S_DONE);
  assign done_o    = state == S_DONE;
  assign abort_now = abort_i && busy_o;
  // Cast both truncates and zero-extends, whichever RES_W vs DATA_W calls for
  assign res_lane  = RES_W'(bus.result_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    bus.r_addr = rd_ptr;
    bus.w_addr = wr_ptr;
    bus.w_data = '0;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_n = rev ? S_DONE : S_READ;
      S_READ: begin
        bus.read = 1'b1;
        state_n  = S_WAIT;
      end
      S_WAIT: if (last_wait) state_n = S_EXEC;
      S_EXEC: state_n = (last_lane || last_rd) ? S_WRITE : S_READ;
      S_WRITE: begin
        bus.write  = 1'b1;
        bus.w_data = buffer;
        state_n    = (last_rd || last_wr) ? S_DONE : S_READ;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort_now) state_n = S_IDLE;
  end

  // Datapath freezes on abort so pointers and flags keep their pre-abort values
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      lane        <= '0;
      cnt         <= '0;
      buffer      <= '0;
      bus.op_a    <= '0;
      bus.op_b    <= '0;
      overflow_o  <= 1'b0;
      range_err_o <= 1'b0;
    end else if (!abort_now) begin
      case (state)
        S_IDLE, S_DONE: if (start_i) begin
          rd_ptr      <= read_start_addr;
          wr_ptr      <= write_start_addr;
          lane        <= '0;
          buffer      <= '0;
          overflow_o  <= 1'b0;
          range_err_o <= rev;
        end
        S_READ: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (last_wait) begin
            bus.op_a <= bus.r_data[DATA_W-1:0];
            bus.op_b <= bus.r_data[MEM_WORD_SIZE-1:DATA_W];
          end
        end
        S_EXEC: begin
          buffer[lane] <= res_lane;
          if (!(last_lane || last_rd)) begin
            lane   <= lane + LANE_W'(1);
            rd_ptr <= rd_ptr + ADDR_W'(1);
          end
        end
        S_WRITE: begin
          buffer <= '0;
          lane   <= '0;
          if (!last_rd) begin
            if (last_wr) overflow_o <= 1'b1;
            else begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
              rd_ptr <= rd_ptr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/calc_stream_controller.md
Name: calc_stream_controller

Overview:
Parametrised memory-to-memory sequencer for the calculator datapath, replacing the fixed two-halves controller. It reads operand words from a read address window and splits each word into op_a/op_b for the external ALU. ALU results are packed PACK-per-word into an internal buffer and written to a write address window. It adds a start/done/busy handshake, configurable read latency, flush of partial words, overflow detection and abort.

Parameters:
ADDR_W, 9, memory address width
DATA_W, 32, operand width; MEM_WORD_SIZE must equal 2*DATA_W
MEM_WORD_SIZE, 64, memory word width
READ_LAT, 1, read-data latency in cycles (legal 1..4)
PACK, 2, results packed per written word (legal 1, 2, 4); RES_W = MEM_WORD_SIZE/PACK

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  launch; sampled in S_IDLE or S_DONE
abort_i  in  1  synchronous abort; returns to S_IDLE
read_start_addr  in  ADDR_W  first operand address (inclusive)
read_end_addr  in  ADDR_W  last operand address (inclusive)
write_start_addr  in  ADDR_W  first result address (inclusive)
write_end_addr  in  ADDR_W  last result address (inclusive)
read  out  1  memory read strobe
r_addr  out  ADDR_W  read address
r_data  in  MEM_WORD_SIZE  read data, valid READ_LAT cycles after read
write  out  1  memory write strobe
w_addr  out  ADDR_W  write address
w_data  out  MEM_WORD_SIZE  packed result word
op_a  out  DATA_W  registered r_data[DATA_W-1:0]
op_b  out  DATA_W  registered r_data[MEM_WORD_SIZE-1:DATA_W]
result_i  in  DATA_W  combinational ALU result of op_a/op_b
busy_o  out  1  high in every state except S_IDLE and S_DONE
done_o  out  1  high while in S_DONE
overflow_o  out  1  write window exhausted before reads finished
range_err_o  out  1  start_addr > end_addr on either window at launch

Behaviour:
- Reset (async, any state): state S_IDLE. All outputs 0, including pointers, lane count, pack buffer, op_a and op_b.
- Launch: start_i in S_IDLE/S_DONE loads rd_ptr<=read_start_addr, wr_ptr<=write_start_addr, lane<=0, buffer<=0, and clears done_o/overflow_o/range_err_o.
  - Either window reversed -> S_DONE with range_err_o=1. No memory access occurs.
  - Otherwise -> S_READ.
- S_READ (1 cycle): read=1, r_addr=rd_ptr -> S_WAIT.
- S_WAIT (READ_LAT cycles, internal counter): on the last cycle, op_a/op_b <= r_data halves -> S_EXEC.
- S_EXEC (1 cycle): buffer lane[lane] <= result_i[RES_W-1:0]. If RES_W > DATA_W, result is zero-extended; otherwise upper bits are truncated.
  - last_rd is defined as rd_ptr==read_end_addr.
  - If lane==PACK-1 or last_rd -> S_WRITE.
  - Else lane++, rd_ptr++ -> S_READ.
- Lane order: first result in bits [RES_W-1:0]; unfilled lanes are written as zero (partial-word flush).
- S_WRITE (1 cycle): write=1, w_addr=wr_ptr, w_data=buffer. Then buffer<=0 and lane<=0.
  - last_rd -> S_DONE.
  - Else if wr_ptr==write_end_addr -> S_DONE with overflow_o=1.
  - Else wr_ptr++, rd_ptr++ -> S_READ.
- S_DONE: done_o held high. start_i relaunches. Status flags hold until the next launch.
- read and write are never asserted in the same cycle. When idle, r_addr=rd_ptr and w_addr=wr_ptr; w_data=0 outside S_WRITE.
- abort_i in any busy state -> S_IDLE next cycle. The current strobe completes; no further read or write is issued. Flags are unchanged and done_o stays 0. Abort has priority over all transitions.
- start_i while busy is ignored.
- Timing: each result costs 2+READ_LAT cycles, plus 1 cycle per written word. No pointer wrap-around is possible: pointers stop at their end addresses.

Test Plan:
- Nominal, PACK=2, READ_LAT=1: read 0..3, write 8..9, each word {b=k, a=k}, result_i=op_a+op_b -> 2 writes. w_data[8] = {32'd2, 32'd0} and w_data[9] = {32'd6, 32'd4}. done_o rises 14 cycles after start is sampled.
- Odd count: read 0..2, write 8..9 -> w_data[9] = {32'd0, result2}; exactly 2 writes; overflow_o=0.
- Overflow: read 0..5, write 8..8, PACK=2 -> 1 write, to addr 8; overflow_o=1; read never issued to addr 2.
- READ_LAT=3: read strobe at cycle t; op_a updates at edge t+3; 5 cycles per result; no read/write overlap.
- Abort / reset: abort_i in S_WAIT of 2nd result -> S_IDLE, no write issued, done_o=0. Async rst_i asserted mid-S_WRITE -> all outputs 0 immediately, without waiting for a clock edge. A subsequent start runs the nominal case correctly.
- Range error: read_start=5, read_end=3 -> done_o and range_err_o=1 one cycle after start; read and write stay 0.
